// File: rtl/ex_cond_stage_pkg.sv
// Shared constants for the decode->execute control word and ARM-style condition codes.
package ex_cond_stage_pkg;

  localparam int unsigned AluCtlW = 4;
  localparam int unsigned CondW   = 4;
  localparam int unsigned FlagsW  = 4;

  typedef enum logic [CondW-1:0] {
    CondEq = 4'h0, CondNe = 4'h1, CondCs = 4'h2, CondCc = 4'h3,
    CondMi = 4'h4, CondPl = 4'h5, CondVs = 4'h6, CondVc = 4'h7,
    CondHi = 4'h8, CondLs = 4'h9, CondGe = 4'hA, CondLt = 4'hB,
    CondGt = 4'hC, CondLe = 4'hD, CondAl = 4'hE, CondNv = 4'hF
  } cond_e;

  // NZCV bit positions inside the flag vector
  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  localparam logic [AluCtlW-1:0] AluNop = 4'h0;

  typedef struct packed {
    logic               alu_src;
    logic [AluCtlW-1:0] alu_control;
    logic               mem_to_reg;
    logic               reg_write;
    logic               mem_write;
    logic               plus_one;
    logic               branch;
    logic               pcsrc;
    logic [1:0]         flag_w;
    logic [CondW-1:0]   cond;
  } ctrl_t;

  localparam ctrl_t CtrlBubble = '{
    alu_src:     1'b0,
    alu_control: AluNop,
    mem_to_reg:  1'b0,
    reg_write:   1'b0,
    mem_write:   1'b0,
    plus_one:    1'b0,
    branch:      1'b0,
    pcsrc:       1'b0,
    flag_w:      2'b00,
    cond:        CondAl
  };

endpackage

// File: rtl/ex_cond_stage_cond_check.sv
// Combinational condition evaluator: 4-bit condition field against NZCV flags.
module ex_cond_stage_cond_check
  import ex_cond_stage_pkg::*;
(
  input  logic [CondW-1:0]  cond,
  input  logic [FlagsW-1:0] flags,
  output logic              cond_ex
);

  logic n, z, c, v;

  always_comb begin
    n = flags[FlagN];
    z = flags[FlagZ];
    c = flags[FlagC];
    v = flags[FlagV];
    cond_ex = 1'b0;
    unique case (cond)
      CondEq:  cond_ex = z;
      CondNe:  cond_ex = !z;
      CondCs:  cond_ex = c;
      CondCc:  cond_ex = !c;
      CondMi:  cond_ex = n;
      CondPl:  cond_ex = !n;
      CondVs:  cond_ex = v;
      CondVc:  cond_ex = !v;
      CondHi:  cond_ex = c & !z;
      CondLs:  cond_ex = !c | z;
      CondGe:  cond_ex = (n == v);
      CondLt:  cond_ex = (n != v);
      CondGt:  cond_ex = !z & (n == v);
      CondLe:  cond_ex = z | (n != v);
      CondAl:  cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_cond_stage.sv
// Decode->execute control register with NZCV flag register and conditional side-effect gating.
module ex_cond_stage
  import ex_cond_stage_pkg::*;
#(
  parameter int unsigned ALUCTL_W = 4,
  parameter int unsigned COND_W   = 4,
  parameter int unsigned FLAGS_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_e,
  input  logic                flush_e,
  input  logic [COND_W-1:0]   cond_d,
  input  logic                alu_src_d,
  input  logic [ALUCTL_W-1:0] alu_control_d,
  input  logic                mem_to_reg_d,
  input  logic                reg_write_d,
  input  logic                mem_write_d,
  input  logic                plus_one_d,
  input  logic                branch_d,
  input  logic                pcsrc_d,
  input  logic [1:0]          flag_w_d,
  input  logic [FLAGS_W-1:0]  alu_flags_e,
  output logic                alu_src_e,
  output logic [ALUCTL_W-1:0] alu_control_e,
  output logic                mem_to_reg_e,
  output logic                plus_one_e,
  output logic                reg_write_e,
  output logic                mem_write_e,
  output logic                branch_taken_e,
  output logic                cond_ex_e,
  output logic [FLAGS_W-1:0]  flags_q
);

  ctrl_t              ctrl_q, ctrl_d;
  logic [FLAGS_W-1:0] flags_d;
  logic               cond_ex;

  ex_cond_stage_cond_check u_cond_check (
    .cond    (ctrl_q.cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  always_comb begin
    ctrl_d = ctrl_q;
    if (flush_e) begin
      ctrl_d = CtrlBubble;
    end else if (!stall_e) begin
      ctrl_d.alu_src     = alu_src_d;
      ctrl_d.alu_control = alu_control_d;
      ctrl_d.mem_to_reg  = mem_to_reg_d;
      ctrl_d.reg_write   = reg_write_d;
      ctrl_d.mem_write   = mem_write_d;
      ctrl_d.plus_one    = plus_one_d;
      ctrl_d.branch      = branch_d;
      ctrl_d.pcsrc       = pcsrc_d;
      ctrl_d.flag_w      = flag_w_d;
      ctrl_d.cond        = cond_d;
    end
  end

  // Flags commit for the instruction in E even when a flush is loading a bubble behind it
  always_comb begin
    flags_d = flags_q;
    if (cond_ex && !stall_e) begin
      if (ctrl_q.flag_w[1]) flags_d[FlagN:FlagZ] = alu_flags_e[FlagN:FlagZ];
      if (ctrl_q.flag_w[0]) flags_d[FlagC:FlagV] = alu_flags_e[FlagC:FlagV];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= CtrlBubble;
      flags_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    alu_src_e      = ctrl_q.alu_src;
    alu_control_e  = ctrl_q.alu_control;
    mem_to_reg_e   = ctrl_q.mem_to_reg;
    plus_one_e     = ctrl_q.plus_one & cond_ex;
    reg_write_e    = ctrl_q.reg_write & cond_ex;
    mem_write_e    = ctrl_q.mem_write & cond_ex;
    branch_taken_e = (ctrl_q.branch | ctrl_q.pcsrc) & cond_ex;
    cond_ex_e      = cond_ex;
  end

endmodule

// File: tb/tb_ex_cond_stage.sv
// Directed plus randomized bench for ex_cond_stage against a behavioural pipeline/flag model.
module tb_ex_cond_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall_e, flush_e;
  logic [3:0] cond_d, alu_control_d, alu_flags_e;
  logic       alu_src_d, mem_to_reg_d, reg_write_d, mem_write_d, plus_one_d, branch_d, pcsrc_d;
  logic [1:0] flag_w_d;
  logic       alu_src_e, mem_to_reg_e, plus_one_e, reg_write_e, mem_write_e;
  logic       branch_taken_e, cond_ex_e;
  logic [3:0] alu_control_e, flags_q;

  int checks = 0;
  int errors = 0;

  // Model of what sits in E and of the architectural flags
  logic       m_src, m_m2r, m_rw, m_mw, m_p1, m_br, m_pcs;
  logic [3:0] m_ctl, m_cond, m_flags;
  logic [1:0] m_fw;
  logic [3:0] snap;

  localparam logic [3:0] Nop = 4'h0;

  always #5 clk = ~clk;

  ex_cond_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_e(stall_e), .flush_e(flush_e),
    .cond_d(cond_d), .alu_src_d(alu_src_d), .alu_control_d(alu_control_d),
    .mem_to_reg_d(mem_to_reg_d), .reg_write_d(reg_write_d), .mem_write_d(mem_write_d),
    .plus_one_d(plus_one_d), .branch_d(branch_d), .pcsrc_d(pcsrc_d), .flag_w_d(flag_w_d),
    .alu_flags_e(alu_flags_e), .alu_src_e(alu_src_e), .alu_control_e(alu_control_e),
    .mem_to_reg_e(mem_to_reg_e), .plus_one_e(plus_one_e), .reg_write_e(reg_write_e),
    .mem_write_e(mem_write_e), .branch_taken_e(branch_taken_e), .cond_ex_e(cond_ex_e),
    .flags_q(flags_q)
  );

  // Even codes test a predicate, odd codes its complement; 111x is AL / never.
  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return c == 4'hE;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_bubble();
    {m_src, m_m2r, m_rw, m_mw, m_p1, m_br, m_pcs} = '0;
    m_ctl = Nop; m_fw = 2'b00; m_cond = 4'hE;
  endtask

  task automatic check_all();
    logic cx;
    cx = cond_ref(m_cond, m_flags);
    chk("alu_src", 8'(alu_src_e), 8'(m_src));
    chk("alu_control", 8'(alu_control_e), 8'(m_ctl));
    chk("mem_to_reg", 8'(mem_to_reg_e), 8'(m_m2r));
    chk("plus_one", 8'(plus_one_e), 8'(m_p1 && cx));
    chk("reg_write", 8'(reg_write_e), 8'(m_rw && cx));
    chk("mem_write", 8'(mem_write_e), 8'(m_mw && cx));
    chk("branch_taken", 8'(branch_taken_e), 8'((m_br || m_pcs) && cx));
    chk("cond_ex", 8'(cond_ex_e), 8'(cx));
    chk("flags", 8'(flags_q), 8'(m_flags));
  endtask

  // One clock edge: advance the model from pre-edge inputs, then compare
  task automatic tick();
    logic cx;
    cx = cond_ref(m_cond, m_flags);
    @(posedge clk);
    #1;
    if (cx && !stall_e) begin
      if (m_fw[1]) m_flags[3:2] = alu_flags_e[3:2];
      if (m_fw[0]) m_flags[1:0] = alu_flags_e[1:0];
    end
    if (flush_e) model_bubble();
    else if (!stall_e) begin
      m_src = alu_src_d; m_ctl = alu_control_d; m_m2r = mem_to_reg_d; m_rw = reg_write_d;
      m_mw = mem_write_d; m_p1 = plus_one_d; m_br = branch_d; m_pcs = pcsrc_d;
      m_fw = flag_w_d; m_cond = cond_d;
    end
    check_all();
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    {alu_src_d, mem_to_reg_d, reg_write_d, mem_write_d, plus_one_d, branch_d, pcsrc_d} =
      7'($urandom);
    alu_control_d = 4'($urandom);
    cond_d        = 4'($urandom);
    flag_w_d      = 2'($urandom);
    alu_flags_e   = 4'($urandom);
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic rw,
                       input logic mw, input logic br);
    rand_inputs();
    cond_d = c; flag_w_d = fw; reg_write_d = rw; mem_write_d = mw;
    branch_d = br; pcsrc_d = 1'b0; plus_one_d = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
    rand_inputs();
    model_bubble();
    m_flags = 4'h0;
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_nop", 8'(alu_control_e), 8'(Nop));
    rst_n = 1'b1;

    // SUBS setting Z, then BEQ taken
    drive(4'hE, 2'b11, 1'b1, 1'b0, 1'b0); tick();
    drive(4'h0, 2'b00, 1'b0, 1'b0, 1'b1); alu_flags_e = 4'b0100; tick();
    chk("beq_taken", 8'(branch_taken_e), 8'd1);
    chk("beq_flags", 8'(flags_q), 8'h4);
    // Same with Z clear: not taken
    drive(4'hE, 2'b11, 1'b1, 1'b0, 1'b0); tick();
    drive(4'h0, 2'b00, 1'b0, 1'b0, 1'b1); alu_flags_e = 4'b0000; tick();
    chk("beq_not_taken", 8'(branch_taken_e), 8'd0);

    // Conditional store NE with Z=1 is suppressed and leaves flags alone
    drive(4'hE, 2'b11, 1'b0, 1'b0, 1'b0); tick();
    drive(4'h1, 2'b11, 1'b1, 1'b1, 1'b0); alu_flags_e = 4'b0100; tick();
    chk("ne_mem_write", 8'(mem_write_e), 8'd0);
    chk("ne_reg_write", 8'(reg_write_e), 8'd0);
    drive(4'hE, 2'b00, 1'b0, 1'b0, 1'b0); alu_flags_e = 4'b1011; tick();
    chk("ne_flags_kept", 8'(flags_q), 8'h4);

    // Stall for three cycles with a flag-writing AL instruction in E
    drive(4'hE, 2'b11, 1'b1, 1'b1, 1'b1); tick();
    snap = flags_q;
    stall_e = 1'b1;
    repeat (3) begin rand_inputs(); tick(); chk("stall_flags", 8'(flags_q), 8'(snap)); end
    chk("stall_reg_write", 8'(reg_write_e), 8'd1);
    // Stall and flush together loads a bubble
    flush_e = 1'b1; rand_inputs(); tick();
    chk("flush_wins", 8'({plus_one_e, reg_write_e, mem_write_e, branch_taken_e}), 8'd0);
    stall_e = 1'b0; flush_e = 1'b0;

    // Partial flag write: 1111 then NZ-only write of 0000
    drive(4'hE, 2'b11, 1'b0, 1'b0, 1'b0); tick();
    drive(4'hE, 2'b10, 1'b0, 1'b0, 1'b0); alu_flags_e = 4'hF; tick();
    drive(4'hE, 2'b00, 1'b0, 1'b0, 1'b0); alu_flags_e = 4'h0; tick();
    chk("partial_flags", 8'(flags_q), 8'h3);

    // Sweep every condition against every flag vector
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        drive(4'hE, 2'b11, 1'b0, 1'b0, 1'b0); tick();
        drive(4'(c), 2'b00, 1'b0, 1'b0, 1'b0); alu_flags_e = 4'(f); tick();
        if (c == 15) chk("never", 8'(cond_ex_e), 8'd0);
      end
    end

    // Random traffic with occasional stall/flush and one mid-run async reset
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      stall_e = ($urandom_range(0, 5) == 0);
      flush_e = ($urandom_range(0, 7) == 0);
      if (i == 150) begin
        #2 rst_n = 1'b0;
        #1;
        model_bubble(); m_flags = 4'h0;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
